// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch front-end with redirect flush and in-order response buffering
module fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 'h80020000,
  parameter int PC_STEP = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [DATA_W-1:0] insn_out,
  output logic [ADDR_W-1:0] pc_out
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d, ird_q, ird_d, iwr_q, iwr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [ADDR_W-1:0] ipc_q [DEPTH];
  logic [ADDR_W-1:0] ipc_d [DEPTH];
  logic [DATA_W-1:0] insn_mem_q [DEPTH];
  logic [DATA_W-1:0] insn_mem_d [DEPTH];
  logic [CW:0] live;
  logic req_fire, rsp_fire, push, pop;
  assign live = {1'b0, count_q} + {1'b0, inflight_q} - {1'b0, drop_q};
  assign imem_req_valid = rst && !redirect_valid && live < (CW+1)'(DEPTH) && inflight_q != CW'(DEPTH);
  assign imem_req_addr = fetch_pc_q;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && inflight_q != '0;
  assign push = rsp_fire && drop_q == '0 && !redirect_valid;
  assign insn_valid = count_q != '0;
  assign pop = insn_valid && insn_ready && !redirect_valid;
  assign insn_out = insn_valid ? insn_mem_q[rd_q] : '0;
  assign pc_out = insn_valid ? pc_mem_q[rd_q] : RESET_PC;
  always_comb begin
    fetch_pc_d = redirect_valid ? {redirect_pc[ADDR_W-1:2], 2'b00}
               : req_fire ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);
    drop_d = redirect_valid ? inflight_d : drop_q - CW'(rsp_fire && drop_q != '0);
    count_d = redirect_valid ? '0 : count_q + CW'(push) - CW'(pop);
    rd_d = rd_q + PW'(pop);
    wr_d = redirect_valid ? rd_q : wr_q + PW'(push);
    iwr_d = iwr_q + PW'(req_fire);
    ird_d = ird_q + PW'(rsp_fire);
    pc_mem_d = pc_mem_q;
    insn_mem_d = insn_mem_q;
    ipc_d = ipc_q;
    if (push) begin
      pc_mem_d[wr_q] = ipc_q[ird_q];
      insn_mem_d[wr_q] = imem_rsp_data;
    end
    if (req_fire) ipc_d[iwr_q] = fetch_pc_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      count_q <= '0;
      inflight_q <= '0;
      drop_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      ird_q <= '0;
      iwr_q <= '0;
      pc_mem_q <= '{default: '0};
      insn_mem_q <= '{default: '0};
      ipc_q <= '{default: '0};
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q <= count_d;
      inflight_q <= inflight_d;
      drop_q <= drop_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      ird_q <= ird_d;
      iwr_q <= iwr_d;
      pc_mem_q <= pc_mem_d;
      insn_mem_q <= insn_mem_d;
      ipc_q <= ipc_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: random fetch traffic against an epoch-tagged memory model with a scoreboarded decode side
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] RPC = 32'h80020000;
  logic clk = 0, rst = 0;
  logic redirect_valid = 0, imem_req_ready = 0, imem_rsp_valid = 0, insn_ready = 0;
  logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
  logic imem_req_valid, insn_valid;
  logic [31:0] imem_req_addr, insn_out, pc_out;
  logic w_rv, w_iv;
  logic [31:0] w_ra, w_io, w_po;
  typedef struct {logic [31:0] addr; int due; int ep;} req_t;
  req_t pend[$];
  logic [63:0] expq[$];
  logic [31:0] wq[$];
  int total = 0, bad = 0, epoch = 0, cyc = 0, issue_cnt = 0, combo_hits = 0;
  int lat_min = 1, lat_max = 1, rdy_pct = 100, pop_pct = 100, redir_pm = 0;
  logic force_redir = 0;
  logic [31:0] force_pc = 0, exp_pc = RPC;
  always #5 clk = ~clk;
  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(RPC), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn_out(insn_out), .pc_out(pc_out));
  fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFFFFF8), .PC_STEP(4)) u_wrap (
    .clk(clk), .rst(rst), .redirect_valid(1'b0), .redirect_pc(32'h0),
    .imem_req_valid(w_rv), .imem_req_ready(1'b1), .imem_req_addr(w_ra),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .insn_valid(w_iv), .insn_ready(1'b1), .insn_out(w_io), .pc_out(w_po));
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask
  // memory and control driver: responses come back in order once their due cycle is reached
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    imem_req_ready = $urandom_range(99) < rdy_pct;
    insn_ready = $urandom_range(99) < pop_pct;
    redirect_valid = force_redir || ($urandom_range(999) < redir_pm);
    redirect_pc = force_redir ? force_pc : $urandom;
    if (pend.size() > 0) begin
      imem_rsp_valid = pend[0].due <= cyc;
      imem_rsp_data = imem_rsp_valid ? mem_f(pend[0].addr) : $urandom;
    end else begin
      imem_rsp_valid = $urandom_range(7) == 0;
      imem_rsp_data = $urandom;
    end
  end
  // reference model: a response survives only if no redirect happened since its request was accepted
  always @(negedge clk) begin
    int psize, live;
    logic redir;
    req_t p;
    if (rst) begin
      psize = pend.size();
      live = 0;
      foreach (pend[i]) if (pend[i].ep == epoch) live++;
      redir = redirect_valid;
      chk("insn_valid", {63'b0, insn_valid}, {63'b0, expq.size() != 0});
      chk("req_valid", {63'b0, imem_req_valid},
          {63'b0, !redir && (expq.size() + live < DEPTH) && psize < DEPTH});
      if (imem_req_valid && imem_req_ready) begin
        chk("req_addr", {32'b0, imem_req_addr}, {32'b0, exp_pc});
        pend.push_back('{exp_pc, cyc + int'($urandom_range(lat_max, lat_min)), epoch});
        exp_pc = exp_pc + 4;
        issue_cnt++;
      end
      if (imem_rsp_valid && psize > 0) begin
        p = pend.pop_front();
        if (!redir && p.ep == epoch) expq.push_back({p.addr, mem_f(p.addr)});
      end
      if (redir && imem_rsp_valid && psize > 0 && insn_valid && insn_ready) combo_hits++;
      if (redir) begin
        expq.delete();
        epoch++;
        exp_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end
  always @(negedge clk) begin
    logic [63:0] e;
    #1;
    if (rst && insn_valid && insn_ready && !redirect_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL pop_unexpected actual_pc=%h required=no_insn", pc_out);
      end else begin
        e = expq.pop_front();
        chk("head", {pc_out, insn_out}, e);
      end
    end
  end
  always @(negedge clk) if (rst && w_rv && wq.size() < 3) wq.push_back(w_ra);
  task automatic do_reset();
    @(posedge clk);
    #3 rst = 0;
    pend.delete();
    expq.delete();
    epoch++;
    exp_pc = RPC;
    issue_cnt = 0;
    #1;
    chk("rst_insn_valid", {63'b0, insn_valid}, 64'd0);
    chk("rst_req_valid", {63'b0, imem_req_valid}, 64'd0);
    chk("rst_insn_out", {32'b0, insn_out}, 64'd0);
    chk("rst_pc_out", {32'b0, pc_out}, {32'b0, RPC});
    @(posedge clk);
    #2 rst = 1;
  endtask
  initial begin
    int n;
    repeat (2) @(posedge clk);
    #2;
    chk("init_insn_valid", {63'b0, insn_valid}, 64'd0);
    chk("init_pc_out", {32'b0, pc_out}, {32'b0, RPC});
    rst = 1;
    repeat (20) @(posedge clk);
    pop_pct = 0;
    do_reset();
    repeat (15) @(posedge clk);
    chk("bp_issued", issue_cnt, 4);
    chk("bp_full", {63'b0, insn_valid}, 64'd1);
    pop_pct = 100;
    @(posedge clk);
    pop_pct = 0;
    repeat (10) @(posedge clk);
    chk("bp_one_more", issue_cnt, 5);
    do_reset();
    pop_pct = 100;
    lat_min = 3;
    lat_max = 3;
    n = 0;
    repeat (6) @(posedge clk);
    while (pend.size() != 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("redir_inflight3", pend.size(), 3);
    force_redir = 1;
    force_pc = 32'h80020103;
    @(posedge clk);
    force_redir = 0;
    n = 0;
    @(negedge clk);
    #2;
    while (!insn_valid && n < 50) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("redir_first_pc", {32'b0, pc_out}, 64'h80020100);
    lat_min = 1;
    lat_max = 3;
    redir_pm = 150;
    repeat (600) @(posedge clk);
    chk("combo_seen", {63'b0, combo_hits > 0}, 64'd1);
    lat_max = 6;
    rdy_pct = 70;
    pop_pct = 60;
    redir_pm = 20;
    repeat (3000) @(posedge clk);
    redir_pm = 0;
    if (wq.size() == 3) begin
      chk("wrap0", {32'b0, wq[0]}, 64'hFFFFFFF8);
      chk("wrap1", {32'b0, wq[1]}, 64'hFFFFFFFC);
      chk("wrap2", {32'b0, wq[2]}, 64'h00000000);
    end else begin
      total++;
      bad++;
      $display("FAIL wrap_count actual=%0d required=3", wq.size());
    end
    chk("wrap_idle_valid", {63'b0, w_iv}, 64'd0);
    chk("wrap_idle_out", {w_po, w_io}, {32'hFFFFFFF8, 32'h0});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
